// File: rtl/led7seg_pkg.sv
// Shared definitions for the seven-segment display scanner and its nibble decoder.
package led7seg_pkg;

   typedef enum logic {
      ST_SHOW  = 1'b0,
      ST_BLANK = 1'b1
   } scan_state_e;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   localparam logic [3:0] SA_OFF = 4'b1111;

   // Entry n holds the active-high segment pattern for hex digit n.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   typedef struct packed {
      logic [15:0] data;
      logic [3:0]  dp;
      logic [3:0]  mask;
   } disp_t;

endpackage

// File: rtl/hex7seg_dec.sv
// Hex nibble to seven-segment decoder (active-high, a..g), shared by display users.
module hex7seg_dec
   import led7seg_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   logic [6:0] pattern;

   assign pattern = SEG_TABLE[nibble_i];

   // Bits are routed by segment name so a pin-order change stays in the package.
   always_comb begin
      seg_o        = '0;
      seg_o[SEG_A] = pattern[SEG_A];
      seg_o[SEG_B] = pattern[SEG_B];
      seg_o[SEG_C] = pattern[SEG_C];
      seg_o[SEG_D] = pattern[SEG_D];
      seg_o[SEG_E] = pattern[SEG_E];
      seg_o[SEG_F] = pattern[SEG_F];
      seg_o[SEG_G] = pattern[SEG_G];
   end

endmodule

// File: rtl/led7seg_scan.sv
// Time-multiplexed driver for a shared 4-digit seven-segment bus.
// New values are staged in a pending register and swapped in only at frame start.
module led7seg_scan
   import led7seg_pkg::*;
#(
   parameter int unsigned DIV   = 50000,
   parameter int unsigned BLANK = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        load,
   input  logic [15:0] data,
   input  logic [3:0]  dp,
   input  logic [3:0]  mask,
   output logic        ack,
   output logic        frame_done,
   output logic [7:0]  LED,
   output logic [3:0]  SA
);

   localparam int unsigned CNT_MAX = (DIV > BLANK) ? DIV : BLANK;
   localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

   scan_state_e   state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   disp_t         pend_q, pend_d;
   disp_t         act_q, act_d;
   logic          pendValid_q, pendValid_d;
   logic          apply;

   logic [3:0]    nibble;
   logic [6:0]    segs;
   logic          lit;
   logic [7:0]    led_d;
   logic [3:0]    sa_d;
   logic          frameDone_d;

   // Sequencing: SHOW for DIV cycles, BLANK for BLANK cycles, then the next digit.
   // Disabling parks the scanner at the start of the blank before digit 0.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      apply   = 1'b0;
      if (!en) begin
         state_d = ST_BLANK;
         idx_d   = 2'd3;
         cnt_d   = '0;
      end else if (state_q == ST_SHOW) begin
         if (cnt_q == DIV_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else begin
         if (cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            idx_d   = idx_q + 2'd1;
            cnt_d   = '0;
            apply   = (idx_q == 2'd3) && pendValid_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // A load on the apply edge still lands in pending, after the old value moved out.
   always_comb begin
      pend_d      = pend_q;
      pendValid_d = pendValid_q;
      act_d       = act_q;
      if (apply) begin
         act_d       = pend_q;
         pendValid_d = 1'b0;
      end
      if (load) begin
         pend_d.data = data;
         pend_d.dp   = dp;
         pend_d.mask = mask;
         pendValid_d = 1'b1;
      end
   end

   assign nibble = act_d.data[{idx_d, 2'b00} +: 4];

   hex7seg_dec uDec (
      .nibble_i (nibble),
      .seg_o    (segs)
   );

   // Outputs are computed from next-state values so the pins are registered.
   always_comb begin
      lit   = (state_d == ST_SHOW) && !act_d.mask[idx_d];
      sa_d  = SA_OFF;
      led_d = '0;
      if (lit) begin
         sa_d              = ~(4'b0001 << idx_d);
         led_d[SEG_G:SEG_A] = segs;
         led_d[SEG_DP]      = act_d.dp[idx_d];
      end
      frameDone_d = (state_d == ST_SHOW) && (idx_d == 2'd3) && (cnt_d == DIV_LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_BLANK;
         idx_q       <= 2'd3;
         cnt_q       <= '0;
         pend_q      <= '0;
         act_q       <= '0;
         pendValid_q <= 1'b0;
         ack         <= 1'b0;
         frame_done  <= 1'b0;
         LED         <= 8'h00;
         SA          <= SA_OFF;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         act_q       <= act_d;
         pendValid_q <= pendValid_d;
         ack         <= apply;
         frame_done  <= frameDone_d;
         LED         <= led_d;
         SA          <= sa_d;
      end
   end

endmodule

// File: tb/tb_led7seg_scan.sv
// Self-checking bench for led7seg_scan: directed scenarios plus randomized traffic
// compared every cycle against a frame-position model of the display.
module tb_led7seg_scan;

   localparam int DIV    = 4;
   localparam int BLANK  = 2;
   localparam int SLOT   = DIV + BLANK;
   localparam int FRAME  = 4 * SLOT;
   localparam int FD_POS = 3 * SLOT + DIV - 1;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        en    = 1'b0;
   logic        load  = 1'b0;
   logic [15:0] data  = '0;
   logic [3:0]  dp    = '0;
   logic [3:0]  mask  = '0;
   logic        ack;
   logic        frame_done;
   logic [7:0]  LED;
   logic [3:0]  SA;

   int nChecks = 0;
   int nErrors = 0;

   led7seg_scan #(.DIV(DIV), .BLANK(BLANK)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .load       (load),
      .data       (data),
      .dp         (dp),
      .mask       (mask),
      .ack        (ack),
      .frame_done (frame_done),
      .LED        (LED),
      .SA         (SA)
   );

   always #5 clk = ~clk;

   // Reference model: position inside a 24-cycle frame, 0 = first SHOW0 cycle.
   // Reset or disable parks the position at the blank that precedes digit 0.
   logic [6:0]  segRef [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   int          mPos;
   int          mDigit;
   logic        mPend;
   logic [15:0] mData, pData;
   logic [3:0]  mDp, pDp, mMask, pMask;
   logic [3:0]  expSa;
   logic [7:0]  expLed;
   logic        expAck, expFd;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mPos = FRAME - BLANK;
         mPend = 1'b0;
         mData = '0; mDp = '0; mMask = '0;
         pData = '0; pDp = '0; pMask = '0;
         expAck = 1'b0;
         expFd = 1'b0;
      end else begin
         expAck = 1'b0;
         expFd = 1'b0;
         if (!en) begin
            mPos = FRAME - BLANK;
         end else begin
            mPos = (mPos + 1) % FRAME;
            if (mPos == 0 && mPend) begin
               mData = pData; mDp = pDp; mMask = pMask;
               mPend = 1'b0;
               expAck = 1'b1;
            end
            expFd = (mPos == FD_POS);
         end
         if (load) begin
            pData = data; pDp = dp; pMask = mask;
            mPend = 1'b1;
         end
      end
      mDigit = mPos / SLOT;
      if ((mPos % SLOT) < DIV && !mMask[mDigit]) begin
         expSa  = ~(4'b0001 << mDigit);
         expLed = {mDp[mDigit], segRef[mData[mDigit*4 +: 4]]};
      end else begin
         expSa  = 4'hF;
         expLed = 8'h00;
      end
   end

   task automatic test_reset();
      logic [3:0] saTab  [8] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hD};
      logic [7:0] ledTab [8] = '{8'h00, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h00, 8'h00, 8'h3F};
      en = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      nChecks++;
      if (SA !== 4'hF || LED !== 8'h00 || ack !== 1'b0 || frame_done !== 1'b0) begin
         nErrors++;
         $display("[TB] FAIL reset_immediate: SA=%b LED=%h ack=%b fd=%b, expected 1111 00 0 0", SA, LED, ack, frame_done);
      end
      repeat (2) begin
         @(negedge clk);
         nChecks++;
         if (SA !== 4'hF || LED !== 8'h00) begin
            nErrors++;
            $display("[TB] FAIL reset_hold: SA=%b LED=%h, expected 1111 00", SA, LED);
         end
      end
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         nChecks++;
         if (SA !== saTab[c] || LED !== ledTab[c]) begin
            nErrors++;
            $display("[TB] FAIL startup edge%0d: SA=%b LED=%h, expected SA=%b LED=%h", c + 1, SA, LED, saTab[c], ledTab[c]);
         end
         nChecks++;
         if ({SA, LED, ack, frame_done} !== {expSa, expLed, expAck, expFd}) begin
            nErrors++;
            $display("[TB] FAIL startup_model pos=%0d: SA=%b LED=%h ack=%b fd=%b, expected SA=%b LED=%h ack=%b fd=%b",
                     mPos, SA, LED, ack, frame_done, expSa, expLed, expAck, expFd);
         end
      end
   endtask

   task automatic test_load_basic();
      int ackCount = 0;
      int ackCyc = -1;
      logic [7:0] seen [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
      logic [7:0] want [4] = '{8'h06, 8'hEF, 8'h77, 8'h66};
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         nChecks++;
         if ({SA, LED, ack, frame_done} !== {expSa, expLed, expAck, expFd}) begin
            nErrors++;
            $display("[TB] FAIL load_basic_model pos=%0d: SA=%b LED=%h ack=%b fd=%b, expected SA=%b LED=%h ack=%b fd=%b",
                     mPos, SA, LED, ack, frame_done, expSa, expLed, expAck, expFd);
         end
         if (ack === 1'b1) begin
            ackCount++;
            if (ackCyc < 0) ackCyc = c;
         end
         if (ackCyc >= 0 && c - ackCyc < FRAME)
            for (int k = 0; k < 4; k++)
               if (SA === ~(4'b0001 << k)) seen[k] = LED;
         load = (c == 0);
         if (c == 0) begin
            data = 16'h4A91; dp = 4'b0010; mask = 4'b0000;
         end
      end
      nChecks++;
      if (ackCount !== 1) begin
         nErrors++;
         $display("[TB] FAIL load_basic_ack_count: got %0d, expected 1", ackCount);
      end
      for (int k = 0; k < 4; k++) begin
         nChecks++;
         if (seen[k] !== want[k]) begin
            nErrors++;
            $display("[TB] FAIL load_basic_digit%0d: LED=%h, expected %h", k, seen[k], want[k]);
         end
      end
   endtask

   task automatic test_overwrite();
      bit l1 = 0, l2 = 0;
      int ackCount = 0;
      int ackCyc = -1;
      int litGood = 0;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         nChecks++;
         if ({SA, LED, ack, frame_done} !== {expSa, expLed, expAck, expFd}) begin
            nErrors++;
            $display("[TB] FAIL overwrite_model pos=%0d: SA=%b LED=%h ack=%b fd=%b, expected SA=%b LED=%h ack=%b fd=%b",
                     mPos, SA, LED, ack, frame_done, expSa, expLed, expAck, expFd);
         end
         if (ack === 1'b1) begin
            ackCount++;
            if (ackCyc < 0) ackCyc = c;
         end
         if (ackCyc >= 0 && c - ackCyc < FRAME && SA !== 4'hF && LED === 8'h5B) litGood++;
         load = 1'b0;
         if (!l1 && mPos == SLOT + 1) begin
            l1 = 1; load = 1'b1; data = 16'h1111; dp = 4'b0000; mask = 4'b0000;
         end else if (l1 && !l2 && mPos == 2 * SLOT) begin
            l2 = 1; load = 1'b1; data = 16'h2222;
         end
      end
      nChecks++;
      if (ackCount !== 1) begin
         nErrors++;
         $display("[TB] FAIL overwrite_ack_count: got %0d, expected 1", ackCount);
      end
      nChecks++;
      if (litGood !== 4 * DIV) begin
         nErrors++;
         $display("[TB] FAIL overwrite_digits_5B: lit cycles showing 5B=%0d, expected %0d", litGood, 4 * DIV);
      end
   endtask

   task automatic test_back_to_back();
      bit lA = 0, lB = 0;
      int acks [$];
      logic [7:0] ledAt [$];
      for (int c = 0; c < 90; c++) begin
         @(negedge clk);
         nChecks++;
         if ({SA, LED, ack, frame_done} !== {expSa, expLed, expAck, expFd}) begin
            nErrors++;
            $display("[TB] FAIL coincident_model pos=%0d: SA=%b LED=%h ack=%b fd=%b, expected SA=%b LED=%h ack=%b fd=%b",
                     mPos, SA, LED, ack, frame_done, expSa, expLed, expAck, expFd);
         end
         if (ack === 1'b1) begin
            acks.push_back(c);
            ledAt.push_back(LED);
         end
         load = 1'b0;
         if (!lA && mPos == 10) begin
            lA = 1; load = 1'b1; data = 16'h3333; dp = 4'b0000; mask = 4'b0000;
         end else if (lA && !lB && mPos == FRAME - 1) begin
            lB = 1; load = 1'b1; data = 16'h7777;
         end
      end
      nChecks++;
      if (acks.size() !== 2) begin
         nErrors++;
         $display("[TB] FAIL coincident_ack_count: got %0d, expected 2", acks.size());
      end else begin
         nChecks++;
         if (acks[1] - acks[0] !== FRAME) begin
            nErrors++;
            $display("[TB] FAIL coincident_ack_spacing: got %0d, expected %0d", acks[1] - acks[0], FRAME);
         end
         nChecks++;
         if (ledAt[0] !== 8'h4F || ledAt[1] !== 8'h07) begin
            nErrors++;
            $display("[TB] FAIL coincident_values: digit0 LED=%h then %h, expected 4f then 07", ledAt[0], ledAt[1]);
         end
      end
   endtask

   task automatic test_mask();
      int ackCyc = -1;
      int dark = 0;
      int fds [$];
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         nChecks++;
         if ({SA, LED, ack, frame_done} !== {expSa, expLed, expAck, expFd}) begin
            nErrors++;
            $display("[TB] FAIL mask_model pos=%0d: SA=%b LED=%h ack=%b fd=%b, expected SA=%b LED=%h ack=%b fd=%b",
                     mPos, SA, LED, ack, frame_done, expSa, expLed, expAck, expFd);
         end
         if (ackCyc < 0 && ack === 1'b1) ackCyc = c;
         if (ackCyc >= 0 && c - ackCyc < 2 * FRAME) begin
            if (mPos >= 2 * SLOT && mPos < 2 * SLOT + DIV && SA === 4'hF && LED === 8'h00) dark++;
            if (frame_done === 1'b1) fds.push_back(c);
         end
         load = (c == 0);
         if (c == 0) begin
            data = 16'h0123; dp = 4'b0000; mask = 4'b0100;
         end
      end
      nChecks++;
      if (dark !== 2 * DIV) begin
         nErrors++;
         $display("[TB] FAIL mask_digit2_dark: dark cycles=%0d, expected %0d", dark, 2 * DIV);
      end
      nChecks++;
      if (fds.size() !== 2) begin
         nErrors++;
         $display("[TB] FAIL mask_frame_done_count: got %0d, expected 2", fds.size());
      end else begin
         nChecks++;
         if (fds[1] - fds[0] !== FRAME) begin
            nErrors++;
            $display("[TB] FAIL mask_frame_done_period: got %0d, expected %0d", fds[1] - fds[0], FRAME);
         end
      end
   endtask

   task automatic test_disturb();
      int acks = 0;
      int n7f = 0;
      for (int c = 0; c < 2 * FRAME && mPos != SLOT + 1; c++) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      nChecks++;
      if (SA !== 4'hF || LED !== 8'h00) begin
         nErrors++;
         $display("[TB] FAIL en_off_dark: SA=%b LED=%h, expected 1111 00", SA, LED);
      end
      load = 1'b1; data = 16'h5555; dp = 4'b0000; mask = 4'b0000;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         load = 1'b0;
         nChecks++;
         if (ack !== 1'b0 || frame_done !== 1'b0 || SA !== 4'hF) begin
            nErrors++;
            $display("[TB] FAIL en_off_quiet: ack=%b fd=%b SA=%b, expected 0 0 1111", ack, frame_done, SA);
         end
      end
      en = 1'b1;
      @(negedge clk);
      nChecks++;
      if (SA !== 4'hF) begin
         nErrors++;
         $display("[TB] FAIL en_restart_blank: SA=%b, expected 1111", SA);
      end
      @(negedge clk);
      nChecks++;
      if (SA !== 4'hE || LED !== 8'h6D || ack !== 1'b1) begin
         nErrors++;
         $display("[TB] FAIL en_restart_show0: SA=%b LED=%h ack=%b, expected 1110 6d 1", SA, LED, ack);
      end
      @(negedge clk);
      load = 1'b1; data = 16'h8888;
      @(negedge clk);
      load = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      nChecks++;
      if (SA !== 4'hF || LED !== 8'h00 || ack !== 1'b0 || frame_done !== 1'b0) begin
         nErrors++;
         $display("[TB] FAIL midframe_reset: SA=%b LED=%h ack=%b fd=%b, expected 1111 00 0 0", SA, LED, ack, frame_done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 2 * FRAME + BLANK + 2; c++) begin
         @(negedge clk);
         nChecks++;
         if ({SA, LED, ack, frame_done} !== {expSa, expLed, expAck, expFd}) begin
            nErrors++;
            $display("[TB] FAIL post_reset_model pos=%0d: SA=%b LED=%h ack=%b fd=%b, expected SA=%b LED=%h ack=%b fd=%b",
                     mPos, SA, LED, ack, frame_done, expSa, expLed, expAck, expFd);
         end
         if (ack === 1'b1) acks++;
         if (LED === 8'h7F) n7f++;
      end
      nChecks++;
      if (acks !== 0 || n7f !== 0) begin
         nErrors++;
         $display("[TB] FAIL reset_drops_pending: acks=%0d cycles_showing_8=%0d, expected 0 0", acks, n7f);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         nChecks++;
         if ({SA, LED, ack, frame_done} !== {expSa, expLed, expAck, expFd}) begin
            nErrors++;
            $display("[TB] FAIL random_model cyc=%0d pos=%0d: SA=%b LED=%h ack=%b fd=%b, expected SA=%b LED=%h ack=%b fd=%b",
                     c, mPos, SA, LED, ack, frame_done, expSa, expLed, expAck, expFd);
         end
         load = ($urandom_range(0, 5) == 0);
         en   = ($urandom_range(0, 24) != 0);
         data = 16'($urandom);
         dp   = 4'($urandom);
         mask = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      end
      load = 1'b0;
      en   = 1'b1;
   endtask

   initial begin
      test_reset();
      test_load_basic();
      test_overwrite();
      test_back_to_back();
      test_mask();
      test_disturb();
      test_random();
      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule
